// File: rtl/param_risc_core.sv
// Multicycle parametrised RISC core: 16-bit instructions, single-port RAM.
// Define CPU_BRANCH_LINK_EN to enable the BL/BX link branches.
module param_risc_core #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] start_pc,
  input  logic [DW-1:0] ram_r_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_w_en,
  output logic [DW-1:0] out,
  output logic          N,
  output logic          V,
  output logic          Z,
  output logic          waiting,
  output logic          halted
);

  localparam logic [4:0] S_RST    = 5'd0;
  localparam logic [4:0] S_LDPC   = 5'd1;
  localparam logic [4:0] S_FETCH  = 5'd2;
  localparam logic [4:0] S_LOADIR = 5'd3;
  localparam logic [4:0] S_DECODE = 5'd4;
  localparam logic [4:0] S_MOVI   = 5'd5;
  localparam logic [4:0] S_NOP    = 5'd6;
  localparam logic [4:0] S_BR     = 5'd7;
  localparam logic [4:0] S_LOAD   = 5'd8;
  localparam logic [4:0] S_EXEC   = 5'd9;
  localparam logic [4:0] S_WB     = 5'd10;
  localparam logic [4:0] S_ADDR   = 5'd11;
  localparam logic [4:0] S_MEMRD  = 5'd12;
  localparam logic [4:0] S_LDWB   = 5'd13;
  localparam logic [4:0] S_STWR   = 5'd14;
  localparam logic [4:0] S_STDONE = 5'd15;
  localparam logic [4:0] S_BL     = 5'd16;
  localparam logic [4:0] S_BXRD   = 5'd17;
  localparam logic [4:0] S_BXLD   = 5'd18;
  localparam logic [4:0] S_HALT   = 5'd19;

  logic [4:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] c_q, c_d;
  logic          n_q, n_d;
  logic          v_q, v_d;
  logic          z_q, z_d;
  logic [AW-1:0] daddr_q, daddr_d;

  logic [DW-1:0] rf_q [8];
  logic          rf_we;
  logic [2:0]    rf_wa;
  logic [DW-1:0] rf_wd;

  logic [2:0]    opcode, rn, rd, rm;
  logic [1:0]    op, sh;
  logic [DW-1:0] sximm8;
  logic [AW-1:0] sximm5;
  logic [DW-1:0] shb, diff, alu_res;
  logic          ovf, taken;
  logic          is_movi, is_movr, is_alu, is_cmp;
  logic          is_ldr, is_str, is_br, is_halt;
  logic          is_bl, is_bx;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];
  assign sximm8 = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{(AW-5){ir_q[4]}}, ir_q[4:0]};

  assign is_movi = opcode == 3'b110 && op == 2'b10;
  assign is_movr = opcode == 3'b110 && op == 2'b00;
  assign is_alu  = opcode == 3'b101;
  assign is_cmp  = is_alu && op == 2'b01;
  assign is_ldr  = opcode == 3'b011 && op == 2'b00;
  assign is_str  = opcode == 3'b100 && op == 2'b00;
  assign is_br   = opcode == 3'b001 && op == 2'b00;
  assign is_halt = opcode == 3'b111 && op == 2'b00;

`ifdef CPU_BRANCH_LINK_EN
  assign is_bl = opcode == 3'b010 && op == 2'b11;
  assign is_bx = opcode == 3'b010 && op == 2'b00;
`else
  assign is_bl = 1'b0;
  assign is_bx = 1'b0;
`endif

  always_comb begin
    unique case (sh)
      2'b00:   shb = b_q;
      2'b01:   shb = b_q << 1;
      2'b10:   shb = b_q >> 1;
      default: shb = {b_q[DW-1], b_q[DW-1:1]};
    endcase
  end

  assign diff = a_q - shb;
  assign ovf  = (a_q[DW-1] ^ shb[DW-1]) & (diff[DW-1] ^ a_q[DW-1]);

  // MOV reg shares the datapath and simply passes the shifted operand
  always_comb begin
    alu_res = shb;
    if (is_alu) begin
      unique case (op)
        2'b00:   alu_res = a_q + shb;
        2'b10:   alu_res = a_q & shb;
        2'b11:   alu_res = ~shb;
        default: alu_res = diff;
      endcase
    end
  end

  always_comb begin
    unique case (rn)
      3'b000:  taken = 1'b1;
      3'b001:  taken = z_q;
      3'b010:  taken = !z_q;
      3'b011:  taken = n_q != v_q;
      3'b100:  taken = (n_q != v_q) | z_q;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    daddr_d = daddr_q;
    rf_we   = 1'b0;
    rf_wa   = rd;
    rf_wd   = c_q;
    unique case (state_q)
      S_RST: state_d = S_LDPC;
      S_LDPC: begin
        pc_d    = start_pc;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOADIR;
      S_LOADIR: begin
        ir_d    = ram_r_data[15:0];
        pc_d    = pc_q + AW'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_movi:                  state_d = S_MOVI;
          is_movr, is_alu,
          is_ldr, is_str:           state_d = S_LOAD;
          is_br:                    state_d = S_BR;
          is_halt:                  state_d = S_HALT;
          is_bl:                    state_d = S_BL;
          is_bx:                    state_d = S_BXRD;
          default:                  state_d = S_NOP;
        endcase
      end
      S_MOVI: begin
        rf_we   = 1'b1;
        rf_wa   = rn;
        rf_wd   = sximm8;
        state_d = S_FETCH;
      end
      S_NOP: state_d = S_FETCH;
      S_BR: begin
        if (taken) pc_d = pc_q + sximm8[AW-1:0];
        state_d = S_FETCH;
      end
      S_LOAD: begin
        a_d     = rf_q[rn];
        b_d     = is_str ? rf_q[rd] : rf_q[rm];
        state_d = (is_ldr || is_str) ? S_ADDR : S_EXEC;
      end
      S_EXEC: begin
        if (is_cmp) begin
          n_d = diff[DW-1];
          v_d = ovf;
          z_d = diff == '0;
        end else begin
          c_d = alu_res;
        end
        state_d = S_WB;
      end
      S_WB: begin
        rf_we   = !is_cmp;
        state_d = S_FETCH;
      end
      S_ADDR: begin
        daddr_d = a_q[AW-1:0] + sximm5;
        state_d = is_ldr ? S_MEMRD : S_STWR;
      end
      S_MEMRD: state_d = S_LDWB;
      S_LDWB: begin
        rf_we   = 1'b1;
        rf_wd   = ram_r_data;
        state_d = S_FETCH;
      end
      S_STWR:   state_d = S_STDONE;
      S_STDONE: state_d = S_FETCH;
      S_BL: begin
        rf_we   = 1'b1;
        rf_wa   = 3'd7;
        rf_wd   = DW'(pc_q);
        pc_d    = pc_q + sximm8[AW-1:0];
        state_d = S_FETCH;
      end
      S_BXRD: begin
        a_d     = rf_q[rd];
        state_d = S_BXLD;
      end
      S_BXLD: begin
        pc_d    = a_q[AW-1:0];
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      daddr_q <= daddr_d;
    end
  end

  // register file is not reset; writes are gated by state, which reset forces
  always_ff @(posedge clk) begin
    if (rf_we) rf_q[rf_wa] <= rf_wd;
  end

  assign ram_addr   = (state_q inside {S_MEMRD, S_LDWB, S_STWR}) ? daddr_q : pc_q;
  assign ram_w_data = b_q;
  assign ram_w_en   = state_q == S_STWR;
  assign out        = c_q;
  assign N          = n_q;
  assign V          = v_q;
  assign Z          = z_q;
  assign halted     = state_q == S_HALT;
  assign waiting    = state_q inside {S_MOVI, S_NOP, S_BR, S_WB, S_LDWB,
                                      S_STDONE, S_BL, S_BXLD};

endmodule
